// File: rtl/wallace_mul_pkg.sv
// ---------------------------------------------------------------------------
// wallace_mul_pkg
// Shared types and constants for the wallace_mul_arbiter block.
//   state_t : sequencer states (IDLE / CALC / HOLD)
//   OP_W    : operand width (32)
//   PROD_W  : product width (64)
//   mag32   : two's-complement magnitude of a 32-bit operand
//   neg64   : two's-complement negation of a 64-bit product
// ---------------------------------------------------------------------------
package wallace_mul_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    // |x| for a signed operand; 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude 2^31.
    function automatic logic [OP_W-1:0] mag32(input logic [OP_W-1:0] x);
        return x[OP_W-1] ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [PROD_W-1:0] neg64(input logic [PROD_W-1:0] x);
        return ~x + 64'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant selection. Searches req from ptr upward,
// wrapping modulo NREQ, and reports the first requester found.
// Ports:
//   req       in  NREQ : pending requests
//   ptr       in  IDW  : highest-priority index for this search
//   en        in  1    : grant may be issued this cycle
//   grant     out NREQ : one-hot grant (zero when en=0 or nothing pending)
//   grant_idx out IDW  : index of the selected requester (valid when any=1)
//   any       out 1    : at least one request pending
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    logic [IDW-1:0] idx_s;
    logic           found_s;

    // Rotating priority search starting at ptr.
    always_comb begin : search_b
        logic [IDW:0] cand;
        idx_s   = '0;
        found_s = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (IDW+1)'(i);
            cand = (cand >= (IDW+1)'(NREQ)) ? (cand - (IDW+1)'(NREQ)) : cand;
            if (!found_s && req[cand[IDW-1:0]]) begin
                found_s = 1'b1;
                idx_s   = cand[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot decode of the selected index, gated by the enable.
    always_comb begin
        grant = '0;
        if (en && found_s) begin
            grant[idx_s] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    assign grant_idx = idx_s;
    assign any       = |req;

endmodule

// File: rtl/wallace.sv
// ---------------------------------------------------------------------------
// wallace
// Combinational 32x32 unsigned multiplier: partial products are reduced by
// layers of 3:2 carry-save compressors (32->22->15->10->7->5->4->3->2 rows)
// and the last two rows are summed with the carry-in.
// Ports:
//   a, b  in  32 : operands
//   cin   in  1  : carry-in to the final adder
//   p     out 64 : product (+cin), modulo 2^64
//   cout  out 1  : carry out of the final adder
// ---------------------------------------------------------------------------
module wallace (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [63:0] p,
    output logic        cout
);

    // Partial-product generation, Wallace reduction and final carry-propagate add.
    always_comb begin : tree_b
        logic [63:0] rows [32];
        logic [63:0] nxt  [32];
        logic [63:0] x, y, z;
        logic [5:0]  n, m;
        logic [64:0] sum;
        x   = 64'd0;
        y   = 64'd0;
        z   = 64'd0;
        sum = 65'd0;
        for (int i = 0; i < 32; i++) begin
            rows[5'(i)] = b[5'(i)] ? ({32'd0, a} << i) : 64'd0;
            nxt[5'(i)]  = 64'd0;
        end
        n = 6'd32;
        m = 6'd0;
        for (int l = 0; l < 8; l++) begin
            for (int j = 0; j < 32; j++) begin
                nxt[5'(j)] = 64'd0;
            end
            m = 6'd0;
            for (int g = 0; g < 11; g++) begin
                if (6'(3*g+2) < n) begin
                    x = rows[5'(3*g)];
                    y = rows[5'(3*g+1)];
                    z = rows[5'(3*g+2)];
                    nxt[m[4:0]]         = x ^ y ^ z;
                    nxt[m[4:0] + 5'd1]  = ((x & y) | (x & z) | (y & z)) << 1;
                    m = m + 6'd2;
                end else begin
                    // Fewer than three rows left in this group: pass them through.
                    if (6'(3*g) < n) begin
                        nxt[m[4:0]] = rows[5'(3*g)];
                        m = m + 6'd1;
                    end else begin
                        m = m;
                    end
                    if (6'(3*g+1) < n) begin
                        nxt[m[4:0]] = rows[5'(3*g+1)];
                        m = m + 6'd1;
                    end else begin
                        m = m;
                    end
                end
            end
            rows = nxt;
            n    = m;
        end
        sum  = {1'b0, rows[0]} + {1'b0, rows[1]} + {64'd0, cin};
        p    = sum[63:0];
        cout = sum[64];
    end

endmodule

// File: rtl/wallace_mul_arbiter.sv
// ---------------------------------------------------------------------------
// wallace_mul_arbiter
// Shares one combinational wallace multiplier among NREQ requesters. A
// round-robin grant latches one operand pair, the tree settles for a full
// CALC cycle, and the 64-bit product is registered and offered with the
// requester ID on a valid/ready response channel.
// Optional feature macro: WALLACE_MUL_SIGNED_EN (adds req_signed and
// two's-complement handling via magnitude multiply + conditional negate).
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   req_valid  [NREQ]: request pending per requester
//   req_ready  [NREQ]: one-hot accept (combinational on req_valid)
//   req_a/req_b      : NREQ packed 32-bit operands
//   req_signed [NREQ]: per-requester signed mode (macro builds only)
//   rsp_valid/ready  : response handshake
//   rsp_id     [IDW] : owner of rsp_p
//   rsp_p      [64]  : product
// ---------------------------------------------------------------------------
module wallace_mul_arbiter
    import wallace_mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
`ifdef WALLACE_MUL_SIGNED_EN
    input  logic [NREQ-1:0]      req_signed,
`endif
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [63:0]          rsp_p
);

    state_t              state_r, state_nxt_s;
    logic [IDW-1:0]      ptr_r, ptr_nxt_s;
    logic [OP_W-1:0]     opa_r, opb_r;
    logic [IDW-1:0]      gid_r;
    logic                rsp_valid_r;
    logic [IDW-1:0]      rsp_id_r;
    logic [PROD_W-1:0]   rsp_p_r;

    logic                arb_en_s, accept_s, any_s;
    logic [NREQ-1:0]     grant_s;
    logic [IDW-1:0]      grant_idx_s;
    logic [OP_W-1:0]     opa_sel_s, opb_sel_s, opa_lat_s, opb_lat_s;
    logic [PROD_W-1:0]   prod_s, prod_fin_s;
    logic                unused_cout_s;

    // Grants are only possible from IDLE, or from HOLD in the cycle the
    // response is taken; held in reset so no requester sees a false accept.
    assign arb_en_s = rst_n && ((state_r == IDLE) || ((state_r == HOLD) && rsp_ready));
    assign accept_s = arb_en_s && any_s;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_r),
        .en        (arb_en_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any       (any_s)
    );

    assign req_ready = grant_s;
    assign opa_sel_s = req_a[OP_W*int'(grant_idx_s) +: OP_W];
    assign opb_sel_s = req_b[OP_W*int'(grant_idx_s) +: OP_W];
    assign ptr_nxt_s = (grant_idx_s == IDW'(NREQ-1)) ? '0 : (grant_idx_s + IDW'(1));

    wallace u_wallace (
        .a    (opa_r),
        .b    (opb_r),
        .cin  (1'b0),
        .p    (prod_s),
        .cout (unused_cout_s)
    );

`ifdef WALLACE_MUL_SIGNED_EN
    logic neg_r, neg_s;

    // Signed requesters are multiplied as magnitudes; the sign is reapplied later.
    always_comb begin
        opa_lat_s = opa_sel_s;
        opb_lat_s = opb_sel_s;
        neg_s     = 1'b0;
        if (req_signed[grant_idx_s]) begin
            opa_lat_s = mag32(opa_sel_s);
            opb_lat_s = mag32(opb_sel_s);
            neg_s     = opa_sel_s[OP_W-1] ^ opb_sel_s[OP_W-1];
        end else begin
            neg_s     = 1'b0;
        end
    end

    assign prod_fin_s = neg_r ? neg64(prod_s) : prod_s;

    // Result sign travels alongside the operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_r <= 1'b0;
        end else if (accept_s) begin
            neg_r <= neg_s;
        end else begin
            neg_r <= neg_r;
        end
    end
`else
    assign opa_lat_s  = opa_sel_s;
    assign opb_lat_s  = opb_sel_s;
    assign prod_fin_s = prod_s;
`endif

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; CALC always lasts exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                state_nxt_s = HOLD;
            end
            HOLD: begin
                if (!rsp_ready) begin
                    state_nxt_s = HOLD;
                end else if (accept_s) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand capture, round-robin pointer and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= '0;
            opa_r       <= '0;
            opb_r       <= '0;
            gid_r       <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_p_r     <= '0;
        end else begin
            if (accept_s) begin
                opa_r <= opa_lat_s;
                opb_r <= opb_lat_s;
                gid_r <= grant_idx_s;
                ptr_r <= ptr_nxt_s;
            end else begin
                ptr_r <= ptr_r;
            end
            if (state_r == CALC) begin
                rsp_p_r     <= prod_fin_s;
                rsp_id_r    <= gid_r;
                rsp_valid_r <= 1'b1;
            end else if ((state_r == HOLD) && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_p     = rsp_p_r;

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wallace_mul_arbiter
// Directed self-checking bench for wallace_mul_arbiter (NREQ=4). Inputs are
// driven and outputs sampled 1 time unit after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_wallace_mul_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
`ifdef WALLACE_MUL_SIGNED_EN
    logic [NREQ-1:0]    req_signed;
`endif
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [63:0]        rsp_p;

    int checks = 0;
    int passes = 0;

    wallace_mul_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
`ifdef WALLACE_MUL_SIGNED_EN
        .req_signed (req_signed),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_p      (rsp_p)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load the RR operand set: requester i gets a=i+7, b=i+100.
    task automatic load_rr_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = 32'(i + 7);
            req_b[i*32 +: 32] = 32'(i + 100);
        end
    endtask

    // One complete transaction for requester idx, bounded by cycle budgets.
    task automatic run_one(input int idx, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] p, output logic [IDW-1:0] id, output bit ok);
        ok = 1'b1;
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_valid = 4'b0001 << idx;
        rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 8 && req_ready[idx] !== 1'b1; c++) tick();
        if (req_ready[idx] !== 1'b1) ok = 1'b0;
        tick();
        req_valid = '0;
        for (int c = 0; c < 8 && rsp_valid !== 1'b1; c++) tick();
        if (rsp_valid !== 1'b1) ok = 1'b0;
        p  = rsp_p;
        id = rsp_id;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1; req_a = '0; req_b = '0;
`ifdef WALLACE_MUL_SIGNED_EN
        req_signed = '0;
`endif
        tick(); tick();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passes++;
        checks++; if (rsp_p !== 64'd0) $display("FAIL reset_rsp_p: got %h want 0", rsp_p); else passes++;
        checks++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); else passes++;
        checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else passes++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req_a[31:0] = 32'd3; req_b[31:0] = 32'd5; req_valid = 4'b0001; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL single_accept: got %b want 0001", req_ready); else passes++;
        tick();
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL single_calc_valid: got %b want 0", rsp_valid); else passes++;
        tick();
        checks++; if (rsp_valid !== 1'b1) $display("FAIL single_t2_valid: got %b want 1", rsp_valid); else passes++;
        checks++; if (rsp_p !== 64'd15) $display("FAIL single_p: got %0d want 15", rsp_p); else passes++;
        checks++; if (rsp_id !== 2'd0) $display("FAIL single_id: got %0d want 0", rsp_id); else passes++;
        tick();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL single_t3_valid: got %b want 0", rsp_valid); else passes++;
    endtask

    task automatic test_round_robin();
        int exp_g;
        test_reset();
        load_rr_ops();
        req_valid = 4'b1111; rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_g = k % 4;
            checks++; if (req_ready !== (4'b0001 << exp_g))
                $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'b0001 << exp_g); else passes++;
            if (k > 0) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((k-1) % 4))
                    $display("FAIL rr_rsp_id%0d: got v=%b id=%0d want v=1 id=%0d", k, rsp_valid, rsp_id, (k-1) % 4); else passes++;
                checks++; if (rsp_p !== 64'(((k-1) % 4 + 7) * ((k-1) % 4 + 100)))
                    $display("FAIL rr_rsp_p%0d: got %0d want %0d", k, rsp_p, ((k-1) % 4 + 7) * ((k-1) % 4 + 100)); else passes++;
            end
            tick();
            checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000)
                $display("FAIL rr_calc%0d: got v=%b rdy=%b want v=0 rdy=0000", k, rsp_valid, req_ready); else passes++;
            tick();
        end
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 64'd700)
            $display("FAIL rr_last: got v=%b id=%0d p=%0d want v=1 id=0 p=700", rsp_valid, rsp_id, rsp_p); else passes++;
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        // ptr is 1 here; req0 alone is still granted.
        req_a[31:0] = 32'd6; req_b[31:0] = 32'd7; req_valid = 4'b0001; rsp_ready = 1'b0;
        #1;
        tick();
        req_valid = 4'b0110;
        req_a[63:32] = 32'd11; req_b[63:32] = 32'd12;
        req_a[95:64] = 32'd13; req_b[95:64] = 32'd14;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_p !== 64'd42 || rsp_id !== 2'd0 || req_ready !== 4'b0000)
                $display("FAIL bp_hold%0d: got v=%b p=%0d id=%0d rdy=%b want v=1 p=42 id=0 rdy=0000",
                         k, rsp_valid, rsp_p, rsp_id, req_ready); else passes++;
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) $display("FAIL bp_release_grant: got %b want 0010", req_ready); else passes++;
        tick();
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_calc_valid: got %b want 0", rsp_valid); else passes++;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_p !== 64'd132)
            $display("FAIL bp_req1_rsp: got v=%b id=%0d p=%0d want v=1 id=1 p=132", rsp_valid, rsp_id, rsp_p); else passes++;
        tick();
    endtask

    task automatic test_max_operands();
        logic [63:0] p; logic [IDW-1:0] id; bit ok;
        run_one(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, id, ok);
        checks++; if (!ok || p !== 64'hFFFF_FFFE_0000_0001 || id !== 2'd3)
            $display("FAIL max_ff_ff: got ok=%b p=%h id=%0d want ok=1 p=fffffffe00000001 id=3", ok, p, id); else passes++;
        run_one(3, 32'h0, 32'hFFFF_FFFF, p, id, ok);
        checks++; if (!ok || p !== 64'd0)
            $display("FAIL max_zero: got ok=%b p=%h want ok=1 p=0", ok, p); else passes++;
        run_one(1, 32'h0001_0000, 32'h0001_0000, p, id, ok);
        checks++; if (!ok || p !== 64'h1_0000_0000 || id !== 2'd1)
            $display("FAIL pow2: got ok=%b p=%h id=%0d want ok=1 p=100000000 id=1", ok, p, id); else passes++;
        run_one(2, 32'hFFFF_FFFF, 32'd2, p, id, ok);
        checks++; if (!ok || p !== 64'h1_FFFF_FFFE || id !== 2'd2)
            $display("FAIL times2: got ok=%b p=%h id=%0d want ok=1 p=1fffffffe id=2", ok, p, id); else passes++;
    endtask

    task automatic test_reset_mid_calc();
        req_a[31:0] = 32'd9; req_b[31:0] = 32'd9; req_valid = 4'b0001; rsp_ready = 1'b1;
        #1;
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_calc_valid: got %b want 0", rsp_valid); else passes++;
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_no_rsp%0d: got %b want 0", k, rsp_valid); else passes++;
        end
        load_rr_ops();
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL rst_first_grant: got %b want 0001", req_ready); else passes++;
        tick();
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 64'd700)
            $display("FAIL rst_after_rsp: got v=%b id=%0d p=%0d want v=1 id=0 p=700", rsp_valid, rsp_id, rsp_p); else passes++;
        tick();
    endtask

    task automatic test_signed();
        logic [63:0] p; logic [IDW-1:0] id; bit ok;
`ifdef WALLACE_MUL_SIGNED_EN
        req_signed = 4'b0100;
        run_one(2, 32'hFFFF_FFFD, 32'd5, p, id, ok);
        checks++; if (!ok || p !== 64'hFFFF_FFFF_FFFF_FFF1)
            $display("FAIL signed_neg: got ok=%b p=%h want fffffffffffffff1", ok, p); else passes++;
        run_one(2, 32'h8000_0000, 32'h8000_0000, p, id, ok);
        checks++; if (!ok || p !== 64'h4000_0000_0000_0000)
            $display("FAIL signed_minmin: got ok=%b p=%h want 4000000000000000", ok, p); else passes++;
        req_signed = 4'b0000;
`endif
        run_one(2, 32'hFFFF_FFFD, 32'd5, p, id, ok);
        checks++; if (!ok || p !== 64'h0000_0004_FFFF_FFF1)
            $display("FAIL unsigned_fffd: got ok=%b p=%h want 00000004fffffff1", ok, p); else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_max_operands();
        test_reset_mid_calc();
        test_signed();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wallace_mul_arbiter.md
# wallace_mul_arbiter

Round-robin arbiter and sequencer that shares one instance of the existing 32x32 combinational `wallace` multiplier among `NREQ` requesters. It registers the granted operands, gives the Wallace tree and final adder one full clock cycle to settle, and registers the 64-bit product. The result is returned with the requester's ID over a valid/ready response channel. The block sits between the client datapaths and the multiplier, so the long combinational path is bounded by registers on both sides.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..16.
- `IDW`, `$clog2(NREQ)`: width of the response ID (derived; do not override).

Ports:
- `clk`  in  1: single clock; all state is updated on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NREQ: bit i = requester i has an operand pair pending.
- `req_ready`  out  NREQ: one-hot or zero; bit i = requester i is accepted this cycle.
- `req_a`  in  NREQ*32: operand A; requester i uses bits [32i+31:32i].
- `req_b`  in  NREQ*32: operand B, packed the same way.
- `req_signed`  in  NREQ: per-requester two's-complement mode. Present only when `WALLACE_MUL_SIGNED_EN` is defined.
- `rsp_valid`  out  1: a product is available.
- `rsp_ready`  in  1: the consumer takes the product.
- `rsp_id`  out  IDW: index of the requester that owns `rsp_p`.
- `rsp_p`  out  64: product.

## Operation
- FSM states are IDLE, CALC and HOLD. Reset sets state to IDLE.
- IDLE:
  - If any `req_valid` is high, the arbiter picks grant g, asserts `req_ready[g]`, latches `req_a`/`req_b` slice g and g itself into the operand registers, and moves to CALC.
  - Otherwise the block stays in IDLE.
- CALC (exactly 1 cycle):
  - The operand registers drive `wallace`.
  - At the end of the cycle the product is latched into `rsp_p`, the latched g into `rsp_id`, and `rsp_valid` is set. Next state is HOLD.
- HOLD:
  - `rsp_valid` is 1; `rsp_p` and `rsp_id` stay stable.
  - While `rsp_ready` is 0, all `req_ready` are 0.
  - On `rsp_ready`=1 with a pending request, the arbiter grants in the same cycle (as in IDLE) and the block moves to CALC; `rsp_valid` is 0 during that CALC cycle.
  - On `rsp_ready`=1 with no pending request, the block moves to IDLE.
- Arbitration:
  - Round-robin pointer `ptr`, reset value 0.
  - The grant is the first i with `req_valid[i]`=1, searching from `ptr` upward and wrapping modulo NREQ.
  - On an accept, `ptr` becomes (g+1) mod NREQ. Without an accept, `ptr` is unchanged.
- `req_ready` may depend combinationally on `req_valid`. A requester holds `req_valid` and its operands stable until it sees `req_ready`.
- Arithmetic:
  - Unsigned 32x32 to 64, exact, with no truncation.
  - The `wallace` carry-in is tied to 0 and its carry-out is ignored, since the product always fits in 64 bits.

## Timing
- An accept (`req_valid[g]` and `req_ready[g]`) in cycle T produces `rsp_valid`=1 in cycle T+2.
- Peak throughput is one product every 2 cycles, reached when `rsp_ready` is held at 1.
- Reset values: `rsp_valid`=0, `rsp_p`=0, `rsp_id`=0, `req_ready`=0 (state IDLE), `ptr`=0, operand registers 0.
- Asserting reset mid-operation, in CALC or HOLD, drops the in-flight product with no response. After release the block starts from IDLE with `ptr`=0.
- The first edge after reset release can already accept a request.

## Configuration
- `WALLACE_MUL_SIGNED_EN` defined:
  - The `req_signed` port exists.
  - When `req_signed[g]`=1, the operands are latched as magnitudes (|x|; 0x80000000 stays 0x80000000) and the XOR of their sign bits is stored.
  - At the CALC edge the product is two's-complement negated if the stored sign is 1.
- Macro not defined:
  - The `req_signed` port is absent and the negation logic is absent.
  - All operands are treated as unsigned.

## Structure
- Package `wallace_mul_pkg` holds the FSM state enum (IDLE/CALC/HOLD) and the constants `OP_W`=32 and `PROD_W`=64.
- Sub-module `rr_arbiter`, parameterised by NREQ, takes `req`, `ptr` and `en`, and outputs `grant` (one-hot), `grant_idx` and `any`.
  - The FSM owns `ptr` and the update enable.
- The existing `wallace` module is instantiated once, unmodified.

## Test plan
- **Single request:** req0 with a=3, b=5 and `rsp_ready`=1. Expect the accept in cycle T, then `rsp_valid` in T+2 with `rsp_p`=15 and `rsp_id`=0; `rsp_valid` drops in T+3.
- **Full round-robin:** all four requesters valid continuously, `rsp_ready`=1. Expect grants in order 0,1,2,3,0, one response every 2 cycles, each `rsp_id` matching its operands.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles while in HOLD with req1 and req2 valid. Expect `rsp_p`/`rsp_id` stable and `req_ready`=0 throughout. On release, req1 is granted in the handshake cycle.
- **Max operands:** a=b=0xFFFFFFFF gives `rsp_p`=0xFFFFFFFE00000001. a=0, b=0xFFFFFFFF gives 0.
- **Reset mid-CALC:** assert `rst_n` low during CALC. Expect `rsp_valid`=0 immediately and no response for that request. After release, with all requesters valid, req0 is granted first.
- **Signed mode:** a=0xFFFFFFFD, b=5.
  - With the macro and `req_signed`=1: 0xFFFFFFFFFFFFFFF1.
  - Without the macro: 0x00000004FFFFFFF1.
  - With the macro, 0x80000000 x 0x80000000 signed gives 0x4000000000000000.
